// File: rtl/muldiv_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sched_if
// Description : EX-stage <-> multiply/divide sequencer handshake and
//               HI/LO write-back bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_sched_if;
    logic        flush;
    logic        op_valid;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        stallreq;
    logic        busy;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    // EX stage side: issues operations, consumes stall and HI/LO writes
    modport master (
        output flush, op_valid, op, src_a, src_b,
        input  stallreq, busy, hi_we, lo_we, hi_o, lo_o
    );

    // Sequencer side
    modport slave (
        input  flush, op_valid, op, src_a, src_b,
        output stallreq, busy, hi_we, lo_we, hi_o, lo_o
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_sched.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sched
// Description : Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX stage.
//               Shift-add multiply and restoring divide on operand
//               magnitudes, sign fix-up on the way out, one-cycle HI/LO
//               write pulse. Optional macro MULDIV_FAST_MUL_EN replaces the
//               iterative multiply with a single-cycle 64-bit multiply.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sched #(
    parameter int ITER = 32
) (
    input  wire           clk,
    input  wire           rst,
    muldiv_sched_if.slave bus
);

    localparam int                 c_cnt_w = $clog2(ITER);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_busy;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [31:0]         r_dvsr;     // multiplicand (MUL) or divisor (DIV)
    logic [63:0]         r_acc;      // {prod_hi, multiplier} or {rem, quot}
    logic                r_is_mul;
    logic                r_neg_q;    // negate product / quotient
    logic                r_neg_r;    // negate remainder
    logic [31:0]         r_hi_hold;
    logic [31:0]         r_lo_hold;

    logic                w_accept;
    logic                w_sign_a;
    logic                w_sign_b;
    logic [31:0]         w_mag_a;
    logic [31:0]         w_mag_b;
    logic [32:0]         w_mul_sum;
    logic [63:0]         w_mul_next;
    logic [32:0]         w_rem_sh;
    logic                w_ge;
    logic [31:0]         w_diff;
    logic [63:0]         w_div_next;
    logic [63:0]         w_prod_neg;
    logic [31:0]         w_quot_neg;
    logic [31:0]         w_rem_neg;
    logic [31:0]         w_res_hi;
    logic [31:0]         w_res_lo;

    // A flushed cycle in IDLE is never an acceptance
    assign w_accept = (r_state == S_IDLE) && bus.op_valid && !bus.flush;

    // op[0]=0 means signed; -0x80000000 wraps to 0x80000000 = 2^31 unsigned
    assign w_sign_a = !bus.op[0] && bus.src_a[31];
    assign w_sign_b = !bus.op[0] && bus.src_b[31];
    assign w_mag_a  = w_sign_a ? (32'd0 - bus.src_a) : bus.src_a;
    assign w_mag_b  = w_sign_b ? (32'd0 - bus.src_b) : bus.src_b;

    // Shift-add step: carry out of the high-half add shifts into bit 63
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + {1'b0, r_dvsr};
    assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[31:1]}
                                 : {1'b0, r_acc[63:1]};

    // Restoring step: shifted remainder needs 33 bits before the compare
    assign w_rem_sh   = r_acc[63:31];
    assign w_ge       = (w_rem_sh >= {1'b0, r_dvsr});
    assign w_diff     = w_rem_sh[31:0] - r_dvsr;
    assign w_div_next = w_ge ? {w_diff, r_acc[30:0], 1'b1}
                             : {w_rem_sh[31:0], r_acc[30:0], 1'b0};

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] w_fast_prod;
    assign w_fast_prod = {32'd0, w_mag_a} * {32'd0, w_mag_b};
`endif

    assign w_prod_neg = 64'd0 - r_acc;
    assign w_quot_neg = 32'd0 - r_acc[31:0];
    assign w_rem_neg  = 32'd0 - r_acc[63:32];

    // Sign fix-up of the magnitude result; divide-by-zero leaves flags clear
    always_comb begin
        w_res_hi = r_acc[63:32];
        w_res_lo = r_acc[31:0];
        if (r_is_mul) begin
            if (r_neg_q) begin
                {w_res_hi, w_res_lo} = w_prod_neg;
            end
        end else begin
            if (r_neg_q) begin
                w_res_lo = w_quot_neg;
            end
            if (r_neg_r) begin
                w_res_hi = w_rem_neg;
            end
        end
    end

    // Sequencer FSM, datapath registers and held result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_dvsr    <= 32'd0;
            r_acc     <= 64'd0;
            r_is_mul  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_hi_hold <= 32'd0;
            r_lo_hold <= 32'd0;
        end else if (bus.flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.op_valid) begin
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                        if (bus.op[1]) begin
                            r_is_mul <= 1'b0;
                            r_dvsr   <= w_mag_b;
                            if (bus.src_b == 32'd0) begin
                                // Fixed divide-by-zero result, no iteration
                                r_acc   <= {bus.src_a, 32'hFFFF_FFFF};
                                r_neg_q <= 1'b0;
                                r_neg_r <= 1'b0;
                                r_state <= S_DONE;
                            end else begin
                                r_acc   <= {32'd0, w_mag_a};
                                r_neg_q <= w_sign_a ^ w_sign_b;
                                r_neg_r <= w_sign_a;
                                r_state <= S_DIV;
                            end
                        end else begin
                            r_is_mul <= 1'b1;
                            r_dvsr   <= w_mag_a;
                            r_neg_q  <= w_sign_a ^ w_sign_b;
                            r_neg_r  <= 1'b0;
`ifdef MULDIV_FAST_MUL_EN
                            r_acc    <= w_fast_prod;
                            r_state  <= S_DONE;
`else
                            r_acc    <= {32'd0, w_mag_b};
                            r_state  <= S_MUL;
`endif
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_next;
                    if (r_cnt == c_last) begin
                        r_cnt   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DIV: begin
                    r_acc <= w_div_next;
                    if (r_cnt == c_last) begin
                        r_cnt   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    // op_valid here still belongs to the completing op
                    r_state   <= S_IDLE;
                    r_busy    <= 1'b0;
                    r_hi_hold <= w_res_hi;
                    r_lo_hold <= w_res_lo;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.stallreq = w_accept || (r_state == S_MUL) || (r_state == S_DIV);
    assign bus.busy     = r_busy;
    assign bus.hi_we    = (r_state == S_DONE) && !bus.flush;
    assign bus.lo_we    = (r_state == S_DONE) && !bus.flush;
    assign bus.hi_o     = (r_state == S_DONE) ? w_res_hi : r_hi_hold;
    assign bus.lo_o     = (r_state == S_DONE) ? w_res_lo : r_lo_hold;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_sched
// Description : Directed self-checking bench for muldiv_sched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sched;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   pulses;

    muldiv_sched_if bus ();

    muldiv_sched #(.ITER(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every write pulse for the flush and back-to-back checks
    always @(negedge clk) begin
        if (bus.hi_we === 1'b1) pulses = pulses + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op (op_valid stays high) and wait for its write pulse
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] ehi,
                          input logic [31:0] elo);
        int          cyc;
        int          stalls;
        int          found;
        logic [31:0] ghi;
        logic [31:0] glo;
        logic        glo_we;
        logic        gstall;
        ghi = 32'hx; glo = 32'hx; glo_we = 1'b0; gstall = 1'bx;
        @(posedge clk); #1;
        bus.op_valid = 1'b1;
        bus.op       = op;
        bus.src_a    = a;
        bus.src_b    = b;
        cyc = 0; stalls = 0; found = -1;
        while (found < 0 && cyc < 100) begin
            @(negedge clk);
            if (cyc == 1 && lat > 1) chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
            if (bus.hi_we === 1'b1) begin
                found  = cyc;
                ghi    = bus.hi_o;
                glo    = bus.lo_o;
                glo_we = bus.lo_we;
                gstall = bus.stallreq;
            end else begin
                if (bus.stallreq === 1'b1) stalls = stalls + 1;
                @(posedge clk); #1;
                cyc = cyc + 1;
            end
        end
        chk({tag, "_lat"},    64'(found),  64'(lat));
        chk({tag, "_stalls"}, 64'(stalls), 64'(lat));
        chk({tag, "_hi"},     64'(ghi),    64'(ehi));
        chk({tag, "_lo"},     64'(glo),    64'(elo));
        chk({tag, "_lo_we"},  64'(glo_we), 64'd1);
        chk({tag, "_stall_done"}, 64'(gstall), 64'd0);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
    endtask

    initial begin
        int p0;
        checks = 0; errors = 0; pulses = 0;
        rst = 1'b1;
        bus.flush = 1'b0; bus.op_valid = 1'b0; bus.op = 2'b00;
        bus.src_a = 32'd0; bus.src_b = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_stallreq", 64'(bus.stallreq), 64'd0);
        chk("rst_busy",     64'(bus.busy),     64'd0);
        chk("rst_hi_we",    64'(bus.hi_we),    64'd0);
        chk("rst_lo_we",    64'(bus.lo_we),    64'd0);
        chk("rst_hi_o",     64'(bus.hi_o),     64'd0);
        chk("rst_lo_o",     64'(bus.lo_o),     64'd0);

        // MULTU max*max, then result holds after the pulse
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT,
               32'hFFFF_FFFE, 32'h0000_0001);
        idle();
        @(negedge clk);
        chk("hold_busy", 64'(bus.busy),  64'd0);
        chk("hold_hi",   64'(bus.hi_o),  64'hFFFF_FFFE);
        chk("hold_lo",   64'(bus.lo_o),  64'h0000_0001);
        chk("hold_we",   64'(bus.hi_we), 64'd0);

        run_op("mult_neg", 2'b00, 32'hFFFF_FFFE, 32'd3, MUL_LAT,
               32'hFFFF_FFFF, 32'hFFFF_FFFA);
        idle();
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, DIV_LAT,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
        idle();
        run_op("divu_100_7", 2'b11, 32'd100, 32'd7, DIV_LAT, 32'd2, 32'd14);
        idle();
        run_op("divu_zero", 2'b11, 32'h0000_1234, 32'd0, 1,
               32'h0000_1234, 32'hFFFF_FFFF);
        idle();
        run_op("div_minint", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT,
               32'h0000_0000, 32'h8000_0000);
        idle();

        // Flush in IDLE with op_valid is not an acceptance
        @(posedge clk); #1;
        bus.flush = 1'b1; bus.op_valid = 1'b1; bus.op = 2'b11;
        bus.src_a = 32'd9; bus.src_b = 32'd4;
        @(negedge clk);
        chk("flush_idle_stall", 64'(bus.stallreq), 64'd0);
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.op_valid = 1'b0;
        @(negedge clk);
        chk("flush_idle_busy", 64'(bus.busy), 64'd0);

        // Flush at DIV iteration 10: abort, no write pulse ever
        p0 = pulses;
        @(posedge clk); #1;
        bus.op_valid = 1'b1; bus.op = 2'b10; bus.src_a = 32'd100; bus.src_b = 32'd7;
        repeat (11) begin
            @(posedge clk); #1;
        end
        bus.flush = 1'b1; bus.op_valid = 1'b0;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_div_busy",  64'(bus.busy),     64'd0);
        chk("flush_div_stall", 64'(bus.stallreq), 64'd0);
        repeat (40) @(negedge clk);
        chk("flush_div_pulses", 64'(pulses - p0), 64'd0);

        run_op("multu_3_5", 2'b01, 32'd3, 32'd5, MUL_LAT, 32'd0, 32'd15);
        idle();

        // Reset mid-operation clears everything, including held result
        @(posedge clk); #1;
        bus.op_valid = 1'b1; bus.op = 2'b11; bus.src_a = 32'd50; bus.src_b = 32'd3;
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1; bus.op_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy",  64'(bus.busy),     64'd0);
        chk("rst_mid_stall", 64'(bus.stallreq), 64'd0);
        chk("rst_mid_lo",    64'(bus.lo_o),     64'd0);

        // Back-to-back with op_valid held: exactly two pulses
        p0 = pulses;
        run_op("b2b_mul", 2'b01, 32'd2, 32'd3, MUL_LAT, 32'd0, 32'd6);
        run_op("b2b_div", 2'b11, 32'd9, 32'd4, DIV_LAT, 32'd1, 32'd2);
        idle();
        repeat (40) @(negedge clk);
        chk("b2b_pulses", 64'(pulses - p0), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
